// File: rtl/bench_stream_gen_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bench_stream_pkg
// Description : Shared types, TUSER field offsets and the payload pattern
//               function for the AXI4-Stream benchmark packet generator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package bench_stream_pkg;

   // Generator FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // TUSER header field positions (first beat of each packet only)
   localparam int MAGIC_LSB      = 104;
   localparam int MAGIC_WIDTH    = 24;
   localparam int PKT_IDX_LSB    = 16;
   localparam int BYTES_LSB      = 0;

   // Beat layout: eight 32-bit words per 256-bit beat
   localparam int WORDS_PER_BEAT = 8;
   localparam int WORD_WIDTH     = 32;

   // Deterministic payload word: packet index, beat index, word index
   function automatic logic [31:0] pattern_word(input logic [15:0] p,
                                                input logic [12:0] b,
                                                input logic [2:0]  k);
      return {p, b, k};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bench_stream_gen_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bench_stream_gen_if
// Description : AXI4-Stream bundle (TVALID/TDATA/TSTRB/TUSER/TLAST/TREADY)
//               with master and slave views.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface bench_stream_gen_if #(
   parameter int DATA_WIDTH = 256,
   parameter int USER_WIDTH = 128
);
   logic                    TVALID;
   logic [DATA_WIDTH-1:0]   TDATA;
   logic [DATA_WIDTH/8-1:0] TSTRB;
   logic [USER_WIDTH-1:0]   TUSER;
   logic                    TLAST;
   logic                    TREADY;

   modport master (
      output TVALID, TDATA, TSTRB, TUSER, TLAST,
      input  TREADY
   );

   modport slave (
      input  TVALID, TDATA, TSTRB, TUSER, TLAST,
      output TREADY
   );
endinterface
`default_nettype wire

// File: rtl/bench_stream_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bench_stream_gen
// Description : AXI4-Stream packet generator for throughput benchmarking.
//               Emits num_pkts packets of pkt_len_beats beats with a
//               deterministic payload and magic-coded TUSER header, optional
//               inter-packet gaps, and counts run cycles and stall cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module bench_stream_gen
   import bench_stream_pkg::*;
#(
   parameter int          C_M_AXIS_DATA_WIDTH  = 256,
   parameter int          C_M_AXIS_TUSER_WIDTH = 128,
   parameter logic [23:0] USER_MAGIC_CODE      = 24'haecafe
) (
   input  wire logic        ACLK,
   input  wire logic        RESET,
   input  wire logic        start,
   input  wire logic [15:0] pkt_len_beats,
   input  wire logic [15:0] num_pkts,
   input  wire logic [7:0]  gap_cycles,
   output logic             busy,
   output logic             done,
   output logic [31:0]      cycle_count,
   output logic [31:0]      stall_count,
   bench_stream_gen_if.master M_AXIS
);

   localparam int STRB_WIDTH = C_M_AXIS_DATA_WIDTH / 8;

   state_t                            r_state;
   state_t                            w_state_next;

   logic [15:0]                       r_len;
   logic [15:0]                       r_npkts;
   logic [7:0]                        r_gap;
   logic [7:0]                        r_gap_cnt;
   logic [15:0]                       r_pkt_idx;
   logic [15:0]                       r_beat_idx;

   logic                              r_tvalid;
   logic [C_M_AXIS_DATA_WIDTH-1:0]    r_tdata;
   logic [STRB_WIDTH-1:0]             r_tstrb;
   logic [C_M_AXIS_TUSER_WIDTH-1:0]   r_tuser;
   logic                              r_tlast;
   logic                              r_busy;
   logic                              r_done;
   logic [31:0]                       r_cycle_count;
   logic [31:0]                       r_stall_count;

   logic                              w_accept;
   logic                              w_hs;
   logic                              w_last_beat;
   logic                              w_last_pkt;
   logic [15:0]                       w_len_in;
   logic [15:0]                       w_len_cur;
   logic [15:0]                       w_bytes;
   logic                              w_load;
   logic [15:0]                       w_ld_pkt;
   logic [15:0]                       w_ld_beat;
   logic [C_M_AXIS_DATA_WIDTH-1:0]    w_beat_data;
   logic [C_M_AXIS_TUSER_WIDTH-1:0]   w_beat_user;

   assign w_accept    = (r_state == ST_IDLE) && start;
   assign w_hs        = r_tvalid && M_AXIS.TREADY;
   assign w_last_beat = (r_beat_idx == 16'(r_len - 16'd1));
   assign w_last_pkt  = (r_pkt_idx == 16'(r_npkts - 16'd1));
   // A zero length request is sent as single-beat packets
   assign w_len_in    = (pkt_len_beats == 16'd0) ? 16'd1 : pkt_len_beats;
   // On the start cycle the length register is not loaded yet
   assign w_len_cur   = (r_state == ST_IDLE) ? w_len_in : r_len;
   assign w_bytes     = {w_len_cur[10:0], 5'b00000};

   // Next-state and beat-load selection
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_ld_pkt     = r_pkt_idx;
      w_ld_beat    = r_beat_idx;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (num_pkts != 16'd0) begin
                  w_state_next = ST_SEND;
                  w_load       = 1'b1;
                  w_ld_pkt     = 16'd0;
                  w_ld_beat    = 16'd0;
               end else begin
                  w_state_next = ST_DONE;
               end
            end
         end
         ST_SEND: begin
            if (w_hs) begin
               if (!w_last_beat) begin
                  w_load    = 1'b1;
                  w_ld_beat = 16'(r_beat_idx + 16'd1);
               end else if (w_last_pkt) begin
                  w_state_next = ST_DONE;
               end else if (r_gap != 8'd0) begin
                  w_state_next = ST_GAP;
               end else begin
                  w_load    = 1'b1;
                  w_ld_pkt  = 16'(r_pkt_idx + 16'd1);
                  w_ld_beat = 16'd0;
               end
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == 8'd1) begin
               w_state_next = ST_SEND;
               w_load       = 1'b1;
               w_ld_pkt     = 16'(r_pkt_idx + 16'd1);
               w_ld_beat    = 16'd0;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Payload and header for the beat selected by the load indices
   always_comb begin
      w_beat_data = '0;
      w_beat_user = '0;
      for (int k = 0; k < WORDS_PER_BEAT; k++) begin
         w_beat_data[k*WORD_WIDTH +: WORD_WIDTH] =
            pattern_word(w_ld_pkt, w_ld_beat[12:0], 3'(k));
      end
      if (w_ld_beat == 16'd0) begin
         w_beat_user[MAGIC_LSB +: MAGIC_WIDTH] = USER_MAGIC_CODE;
         w_beat_user[PKT_IDX_LSB +: 16]        = w_ld_pkt;
         w_beat_user[BYTES_LSB +: 16]          = w_bytes;
      end
   end

   // State register
   always_ff @(posedge ACLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Output beat register: loaded from the pattern, otherwise held
   always_ff @(posedge ACLK) begin
      if (RESET) begin
         r_tvalid   <= 1'b0;
         r_tdata    <= '0;
         r_tstrb    <= '0;
         r_tuser    <= '0;
         r_tlast    <= 1'b0;
         r_pkt_idx  <= 16'd0;
         r_beat_idx <= 16'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_tvalid <= (w_state_next == ST_SEND);
         r_busy   <= (w_state_next == ST_SEND) || (w_state_next == ST_GAP);
         r_done   <= (w_state_next == ST_DONE);
         if (w_load) begin
            r_tdata    <= w_beat_data;
            r_tstrb    <= '1;
            r_tuser    <= w_beat_user;
            r_tlast    <= (w_ld_beat == 16'(w_len_cur - 16'd1));
            r_pkt_idx  <= w_ld_pkt;
            r_beat_idx <= w_ld_beat;
         end
      end
   end

   // Run configuration capture and inter-packet gap countdown
   always_ff @(posedge ACLK) begin
      if (RESET) begin
         r_len     <= 16'd1;
         r_npkts   <= 16'd0;
         r_gap     <= 8'd0;
         r_gap_cnt <= 8'd0;
      end else begin
         if (w_accept) begin
            r_len   <= w_len_in;
            r_npkts <= num_pkts;
            r_gap   <= gap_cycles;
         end
         if ((r_state == ST_SEND) && (w_state_next == ST_GAP)) begin
            r_gap_cnt <= r_gap;
         end else if (r_state == ST_GAP) begin
            r_gap_cnt <= 8'(r_gap_cnt - 8'd1);
         end
      end
   end

   // Benchmark counters: every busy cycle, and every stalled valid cycle
   always_ff @(posedge ACLK) begin
      if (RESET) begin
         r_cycle_count <= 32'd0;
         r_stall_count <= 32'd0;
      end else if (w_accept) begin
         r_cycle_count <= 32'd0;
         r_stall_count <= 32'd0;
      end else if (r_busy) begin
         r_cycle_count <= r_cycle_count + 32'd1;
         if (r_tvalid && !M_AXIS.TREADY) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   assign M_AXIS.TVALID = r_tvalid;
   assign M_AXIS.TDATA  = r_tdata;
   assign M_AXIS.TSTRB  = r_tstrb;
   assign M_AXIS.TUSER  = r_tuser;
   assign M_AXIS.TLAST  = r_tlast;
   assign busy          = r_busy;
   assign done          = r_done;
   assign cycle_count   = r_cycle_count;
   assign stall_count   = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_bench_stream_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_bench_stream_gen
// Description : Directed self-checking bench for bench_stream_gen.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bench_stream_gen;

   logic        ACLK;
   logic        RESET;
   logic        start;
   logic [15:0] pkt_len_beats;
   logic [15:0] num_pkts;
   logic [7:0]  gap_cycles;
   logic        busy;
   logic        done;
   logic [31:0] cycle_count;
   logic [31:0] stall_count;

   int checks;
   int errors;

   bench_stream_gen_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) axis ();

   bench_stream_gen #(
      .C_M_AXIS_DATA_WIDTH  (256),
      .C_M_AXIS_TUSER_WIDTH (128),
      .USER_MAGIC_CODE      (24'haecafe)
   ) dut (
      .ACLK          (ACLK),
      .RESET         (RESET),
      .start         (start),
      .pkt_len_beats (pkt_len_beats),
      .num_pkts      (num_pkts),
      .gap_cycles    (gap_cycles),
      .busy          (busy),
      .done          (done),
      .cycle_count   (cycle_count),
      .stall_count   (stall_count),
      .M_AXIS        (axis)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Hard time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] exp_data(input int p, input int b);
      logic [255:0] d;
      d = '0;
      for (int k = 0; k < 8; k++) begin
         d[k*32 +: 32] = 32'((p << 16) | (b << 3) | k);
      end
      return d;
   endfunction

   function automatic logic [127:0] exp_user(input int p, input int len);
      logic [127:0] u;
      u = '0;
      u[127:104] = 24'haecafe;
      u[31:16]   = 16'(p);
      u[15:0]    = 16'(len * 32);
      return u;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      RESET         = 1'b1;
      start         = 1'b0;
      pkt_len_beats = 16'd0;
      num_pkts      = 16'd0;
      gap_cycles    = 8'd0;
      axis.TREADY   = 1'b1;
      repeat (3) step();

      // Reset state
      chk("rst_tvalid", axis.TVALID, 1'b0);
      chk("rst_tlast",  axis.TLAST,  1'b0);
      chk("rst_tdata",  axis.TDATA,  256'd0);
      chk("rst_tuser",  axis.TUSER,  128'd0);
      chk("rst_tstrb",  axis.TSTRB,  32'd0);
      chk("rst_busy",   busy,        1'b0);
      chk("rst_done",   done,        1'b0);
      chk("rst_cycles", cycle_count, 32'd0);
      chk("rst_stalls", stall_count, 32'd0);
      RESET = 1'b0;
      step();

      // One packet of 4 beats, no back-pressure
      num_pkts = 16'd1; pkt_len_beats = 16'd4; gap_cycles = 8'd0;
      pulse_start();
      chk("t1_busy", busy, 1'b1);
      chk("t1_tstrb", axis.TSTRB, {32{1'b1}});
      for (int b = 0; b < 4; b++) begin
         chk("t1_valid", axis.TVALID, 1'b1);
         chk("t1_data",  axis.TDATA,  exp_data(0, b));
         chk("t1_last",  axis.TLAST,  (b == 3));
         chk("t1_user",  axis.TUSER,  (b == 0) ? exp_user(0, 4) : 128'd0);
         if (b == 2) chk("t1_b2w5", axis.TDATA[191:160], 32'h0000_0015);
         step();
      end
      chk("t1_done",   done,        1'b1);
      chk("t1_nbusy",  busy,        1'b0);
      chk("t1_nvalid", axis.TVALID, 1'b0);
      chk("t1_cycles", cycle_count, 32'd4);
      chk("t1_stalls", stall_count, 32'd0);
      // start coincident with done is ignored
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t1_done_off",   done,        1'b0);
      chk("t1_start_ign",  busy,        1'b0);
      step();
      chk("t1_start_ign2", axis.TVALID, 1'b0);
      chk("t1_hold_cyc",   cycle_count, 32'd4);

      // Two packets of 4 with a 2-cycle gap; start pulses mid-run are ignored
      num_pkts = 16'd2; pkt_len_beats = 16'd4; gap_cycles = 8'd2;
      pulse_start();
      for (int c = 1; c <= 10; c++) begin
         logic ev;
         int   p;
         int   b;
         ev = (c <= 4) || (c >= 7);
         p  = (c >= 7) ? 1 : 0;
         b  = (c >= 7) ? c - 7 : c - 1;
         start = (c == 2) || (c == 5);
         chk("t2_valid", axis.TVALID, ev);
         chk("t2_busy",  busy,        1'b1);
         if (ev) begin
            chk("t2_data", axis.TDATA, exp_data(p, b));
            chk("t2_user", axis.TUSER, (b == 0) ? exp_user(p, 4) : 128'd0);
            chk("t2_last", axis.TLAST, (b == 3));
         end
         step();
      end
      start = 1'b0;
      chk("t2_done",   done,        1'b1);
      chk("t2_cycles", cycle_count, 32'd10);
      chk("t2_stalls", stall_count, 32'd0);
      step();

      // One packet of 3 with TREADY low for 3 cycles on beat 1
      num_pkts = 16'd1; pkt_len_beats = 16'd3; gap_cycles = 8'd0;
      pulse_start();
      chk("t3_b0", axis.TDATA, exp_data(0, 0));
      step();
      axis.TREADY = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk("t3_stall_valid", axis.TVALID, 1'b1);
         chk("t3_stall_data",  axis.TDATA,  exp_data(0, 1));
         chk("t3_stall_last",  axis.TLAST,  1'b0);
         step();
      end
      axis.TREADY = 1'b1;
      chk("t3_b1", axis.TDATA, exp_data(0, 1));
      step();
      chk("t3_b2",      axis.TDATA, exp_data(0, 2));
      chk("t3_b2_last", axis.TLAST, 1'b1);
      step();
      chk("t3_done",   done,        1'b1);
      chk("t3_stalls", stall_count, 32'd3);
      chk("t3_cycles", cycle_count, 32'd6);
      step();

      // Zero packets: immediate done, no beats
      num_pkts = 16'd0; pkt_len_beats = 16'd4;
      pulse_start();
      chk("t4_done",   done,        1'b1);
      chk("t4_valid",  axis.TVALID, 1'b0);
      chk("t4_busy",   busy,        1'b0);
      chk("t4_cycles", cycle_count, 32'd0);
      step();
      chk("t4_done_off", done,        1'b0);
      chk("t4_valid2",   axis.TVALID, 1'b0);

      // Zero length: two back-to-back single-beat packets
      num_pkts = 16'd2; pkt_len_beats = 16'd0; gap_cycles = 8'd0;
      pulse_start();
      for (int p = 0; p < 2; p++) begin
         chk("t5_valid", axis.TVALID, 1'b1);
         chk("t5_data",  axis.TDATA,  exp_data(p, 0));
         chk("t5_last",  axis.TLAST,  1'b1);
         chk("t5_user",  axis.TUSER,  exp_user(p, 1));
         step();
      end
      chk("t5_done",   done,        1'b1);
      chk("t5_cycles", cycle_count, 32'd2);
      step();

      // Reset at beat 2 of 8, then a fresh run
      num_pkts = 16'd1; pkt_len_beats = 16'd8; gap_cycles = 8'd0;
      pulse_start();
      step();
      step();
      chk("t6_b2", axis.TDATA, exp_data(0, 2));
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      chk("t6_rst_valid",  axis.TVALID, 1'b0);
      chk("t6_rst_busy",   busy,        1'b0);
      chk("t6_rst_cycles", cycle_count, 32'd0);
      step();
      num_pkts = 16'd1; pkt_len_beats = 16'd2;
      pulse_start();
      chk("t6_new_valid",  axis.TVALID, 1'b1);
      chk("t6_new_data",   axis.TDATA,  exp_data(0, 0));
      chk("t6_new_user",   axis.TUSER,  exp_user(0, 2));
      chk("t6_new_cycles", cycle_count, 32'd0);
      step();
      chk("t6_new_b1", axis.TDATA, exp_data(0, 1));
      chk("t6_new_last", axis.TLAST, 1'b1);
      step();
      chk("t6_done",   done,        1'b1);
      chk("t6_cycles", cycle_count, 32'd2);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bench_stream_gen.md
# bench_stream_gen

AXI4-Stream packet generator that acts as the transmitting end for `dma_benchmark`'s 256-bit `S_AXIS` slave port. On a start pulse it emits a programmed number of fixed-length packets carrying a deterministic data pattern and a magic-coded TUSER header, with optional idle gaps between packets. It measures total transfer cycles and back-pressure stalls, so throughput can be benchmarked without a host DMA engine.

## Interface
Parameters:
- `C_M_AXIS_DATA_WIDTH`, 256, TDATA width; fixed at 256, with 8 × 32-bit words per beat.
- `C_M_AXIS_TUSER_WIDTH`, 128, TUSER width.
- `USER_MAGIC_CODE`, 24'haecafe, magic code placed in the first-beat TUSER.

Ports:
- `ACLK` in 1: single clock.
- `RESET` in 1: reset; synchronous, active-high.
- `start` in 1: one-cycle start pulse; ignored while `busy`.
- `pkt_len_beats` in 16: beats per packet; 0 is treated as 1. Sampled on accepted `start`.
- `num_pkts` in 16: packets per run. Sampled on accepted `start`.
- `gap_cycles` in 8: idle cycles between packets. Sampled on accepted `start`.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run.
- `cycle_count` out 32: cycles from the first TVALID through the final handshake, inclusive.
- `stall_count` out 32: cycles with `TVALID && !TREADY`.
- `M_AXIS_TVALID` out 1, `M_AXIS_TDATA` out 256, `M_AXIS_TSTRB` out 32, `M_AXIS_TUSER` out 128, `M_AXIS_TLAST` out 1, `M_AXIS_TREADY` in 1: AXI4-Stream master.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE → SEND on `start` with `num_pkts != 0`.
- IDLE → DONE on `start` with `num_pkts == 0`; no beats are sent.
- SEND: on each handshake, `beat_idx` increments.
  - On the last beat with packets remaining: go to GAP if `gap_cycles != 0`, else stay in SEND with the next packet's beat 0.
  - On the last beat of the last packet: go to DONE.
- GAP: TVALID low for exactly `gap_cycles` cycles, then → SEND.
- DONE: one cycle with `done`=1, then → IDLE.
- Beat payload: word k (k=0..7) of beat b in packet p = {p[15:0], b[12:0], k[2:0]}.
- `TSTRB` is all ones on every beat.
- `TLAST` is high on beat `len-1`.
- TUSER on beat 0: [127:104]=`USER_MAGIC_CODE`, [31:16]=p, [15:0]=len×32 bytes (mod 2^16). All other bits 0.
- TUSER on later beats: all 0.
- Counters clear on accepted `start`. They hold their values after DONE until the next start or reset, and wrap modulo 2^32.
- `cycle_count` also counts GAP cycles.

## Timing
- All outputs are registered.
- Reset values: TVALID=0, TLAST=0, TDATA/TUSER=0, TSTRB=0, `busy`=0, `done`=0, both counters 0, state IDLE.
- `start` sampled high in cycle N → `busy`=1 and TVALID=1 with beat 0 in cycle N+1.
- AXIS rule: once TVALID is high, TDATA/TUSER/TLAST/TSTRB are stable until the TREADY handshake. TVALID never depends on TREADY.
- Back-to-back beats: with TREADY held high, throughput is one beat per cycle, including across packet boundaries when `gap_cycles`=0.
- Final handshake in cycle M → `done`=1 and `busy`=0 in cycle M+1. No gap is inserted after the last packet.
- `start` coincident with `done`, or at any time while `busy`=1: ignored.
- `RESET` mid-packet: TVALID=0 on the next edge, the partial packet is abandoned, and counters clear.
- Length 1: TLAST and the TUSER header appear on the same beat.

## Structure
- Package `bench_stream_pkg` holds:
  - the state encoding;
  - TUSER field offsets (MAGIC_LSB=104, PKT_IDX_LSB=16, BYTES_LSB=0);
  - `WORDS_PER_BEAT`=8;
  - a pattern function (p, b, k) → 32-bit word.
- Single module; no sub-module.
- The output beat register is loaded either from the pattern function or held on stall.

## Test plan
- `num_pkts`=1, len=4, gap=0, TREADY=1 → 4 beats, TLAST on the 4th. Beat0 TUSER[127:104]=aecafe, [15:0]=128. Beat 2 word 5 = 0x0000_0015. `cycle_count`=4, `stall_count`=0, `done` one cycle after the last beat.
- `num_pkts`=2, len=4, gap=2, TREADY=1 → beats at cycles 1-4 and 7-10. Second packet TUSER[31:16]=1. `cycle_count`=10.
- `num_pkts`=1, len=3, TREADY low for 3 cycles at beat 1 → TDATA/TLAST stable while stalled. `stall_count`=3, `cycle_count`=6.
- `num_pkts`=0 → `done` pulses at N+1, TVALID never asserts. `pkt_len_beats`=0 → 1-beat packets with TLAST on beat 0 and TUSER[15:0]=32.
- `start` pulsed mid-run → ignored; beat sequence is unchanged.
- `RESET` asserted at beat 2 of 8 → TVALID=0 on the next edge. A new start afterwards runs from packet 0, beat 0 with cleared counters.
